// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-master / one-slave arbiter for the PicoRV32 native memory interface.
//   Master 0 is the debug/program loader, master 1 is the cpu. Whole
//   transactions are serialised: the owning master's request is passed
//   straight through to the slave, and the slave response is routed back to
//   it. A per-grant cycle counter forces completion of a hung transaction.
//
// Parameters
//   RR        0 = fixed priority (m0 wins ties), 1 = round-robin
//   TIMEOUT   grant cycles before a forced completion, 0 disables (<= 65535)
//   ERR_DATA  rdata returned to the master on a forced completion
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   m0_mem_* / m1_mem_*       master request (valid/instr/addr/wdata/wstrb)
//                             and response (ready/rdata)
//   mem_*                     slave request (out) and response (in)
//   grant                     one-hot owner: bit0 = m0, bit1 = m1, 00 = idle
//   err_timeout, err_clear    sticky forced-completion flag and its clear
module mem_arbiter #(
   parameter int          RR       = 0,
   parameter int unsigned TIMEOUT  = 64,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        m0_mem_valid,
   input  logic        m0_mem_instr,
   input  logic [31:0] m0_mem_addr,
   input  logic [31:0] m0_mem_wdata,
   input  logic [3:0]  m0_mem_wstrb,
   output logic        m0_mem_ready,
   output logic [31:0] m0_mem_rdata,
   input  logic        m1_mem_valid,
   input  logic        m1_mem_instr,
   input  logic [31:0] m1_mem_addr,
   input  logic [31:0] m1_mem_wdata,
   input  logic [3:0]  m1_mem_wstrb,
   output logic        m1_mem_ready,
   output logic [31:0] m1_mem_rdata,
   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  grant,
   output logic        err_timeout,
   input  logic        err_clear
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   // Counter value on the last allowed grant cycle.
   localparam logic [15:0] TO_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

   state_t      state;
   logic        last_grant;   // 0 = m0 served last, 1 = m1 served last
   logic [15:0] to_cnt;
   logic        own_valid;
   logic        timeout_hit;
   logic        m0_wins;

   // Request/response steering for the current owner.
   always_comb begin
      own_valid    = 1'b0;
      mem_instr    = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_wstrb    = '0;
      case (state)
         GRANT0: begin
            own_valid = m0_mem_valid;
            mem_instr = m0_mem_instr;
            mem_addr  = m0_mem_addr;
            mem_wdata = m0_mem_wdata;
            mem_wstrb = m0_mem_wstrb;
         end
         GRANT1: begin
            own_valid = m1_mem_valid;
            mem_instr = m1_mem_instr;
            mem_addr  = m1_mem_addr;
            mem_wdata = m1_mem_wdata;
            mem_wstrb = m1_mem_wstrb;
         end
         default: ;
      endcase

      // A real slave completion in the limit cycle takes precedence; an
      // owner that has already dropped valid is an abort, not a timeout.
      timeout_hit = (TIMEOUT != 0) && (state != IDLE) && own_valid &&
                    !mem_ready && (to_cnt == TO_LAST);

      mem_valid    = own_valid && !timeout_hit;
      m0_mem_ready = (state == GRANT0) && (mem_ready || timeout_hit);
      m1_mem_ready = (state == GRANT1) && (mem_ready || timeout_hit);
      m0_mem_rdata = (state != GRANT0) ? 32'd0 : (timeout_hit ? ERR_DATA : mem_rdata);
      m1_mem_rdata = (state != GRANT1) ? 32'd0 : (timeout_hit ? ERR_DATA : mem_rdata);
   end

   // m0 takes the slave when it is alone, under fixed priority, or when m1
   // was served last in round-robin mode.
   assign m0_wins = m0_mem_valid && (!m1_mem_valid || (RR == 0) || last_grant);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         grant       <= 2'b00;
         last_grant  <= 1'b1;
         to_cnt      <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (timeout_hit)
            err_timeout <= 1'b1;
         else if (err_clear)
            err_timeout <= 1'b0;

         case (state)
            IDLE: begin
               to_cnt <= '0;
               if (m0_wins) begin
                  state      <= GRANT0;
                  grant      <= 2'b01;
                  last_grant <= 1'b0;
               end else if (m1_mem_valid) begin
                  state      <= GRANT1;
                  grant      <= 2'b10;
                  last_grant <= 1'b1;
               end
            end
            GRANT0, GRANT1: begin
               // Completion, forced completion and abort all return to IDLE,
               // which guarantees an idle cycle between transactions.
               if (mem_ready || timeout_hit || !own_valid) begin
                  state  <= IDLE;
                  grant  <= 2'b00;
                  to_cnt <= '0;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
               end
            end
            default: begin
               state <= IDLE;
               grant <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master, one-slave arbiter on the PicoRV32 native memory interface. It sits between the masters and bram_controller, replacing ad-hoc valid/addr/wdata/wstrb muxing.
- Master 0 is the debug/program loader.
- Master 1 is the cpu.
- It serialises whole transactions, passes the slave response to the owning master, and guards against a hung slave with a timeout.

Parameters:
RR, 0, 0 = fixed priority (m0 wins ties); 1 = round-robin (tie goes to the master not granted last).
TIMEOUT, 64, cycles in a GRANT state before a forced completion; 0 disables; max 65535.
ERR_DATA, 32'hDEADBEEF, rdata returned to the master on a forced completion.

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  synchronous, active-low reset
m0_mem_valid  in  1  master 0 request
m0_mem_instr  in  1  master 0 fetch flag
m0_mem_addr  in  32  master 0 address
m0_mem_wdata  in  32  master 0 write data
m0_mem_wstrb  in  4  master 0 byte strobes (0000 = read)
m0_mem_ready  out  1  master 0 completion pulse
m0_mem_rdata  out  32  master 0 read data
m1_mem_valid, m1_mem_instr, m1_mem_addr, m1_mem_wdata, m1_mem_wstrb, m1_mem_ready, m1_mem_rdata  (same directions/widths as m0, for master 1)
mem_valid  out  1  slave request
mem_instr  out  1  slave fetch flag
mem_addr  out  32  slave address
mem_wdata  out  32  slave write data
mem_wstrb  out  4  slave byte strobes
mem_ready  in  1  slave completion
mem_rdata  in  32  slave read data
grant  out  2  one-hot owner: bit0 = m0, bit1 = m1; 00 = idle
err_timeout  out  1  sticky flag, set on any forced completion
err_clear  in  1  clears err_timeout

Behaviour:
- Reset: reset_n low at a rising edge forces the following. Synchronous only.
  - state = IDLE, grant = 00, err_timeout = 0, timeout counter = 0.
  - last_grant = m1, so m0 wins the first RR tie.
  - Combinational outputs follow: mem_valid = 0, m*_mem_ready = 0.
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE:
  - Both valids low: stay in IDLE.
  - Exactly one valid high: go to that master's GRANT state at the next edge.
  - Both valids high, RR = 0: go to GRANT0.
  - Both valids high, RR = 1: go to the master other than last_grant.
  - Record the winner in last_grant.
- Latency: a request seen in IDLE at cycle N gives grant and mem_valid at cycle N+1. No request reaches the slave in the IDLE cycle.
- GRANTx datapath: mem_valid, mem_instr, mem_addr, mem_wdata and mem_wstrb are combinational copies of master x's signals.
  - mx_mem_ready = mem_ready.
  - mx_mem_rdata = mem_rdata.
  - The other master sees ready = 0 and rdata = 0, and stays pending.
- Completion: mem_ready high in GRANTx causes the following.
  - One-cycle ready pulse to master x.
  - Next state is IDLE; counter cleared.
  - No back-to-back grant without an IDLE cycle, so a master that drops valid on the edge after ready is never re-issued.
- Abort: master x drops valid in GRANTx with mem_ready low.
  - mem_valid follows it low the same cycle.
  - Next state is IDLE; no ready pulse.
- Timeout: the counter increments every GRANT cycle without mem_ready.
  - When the counter equals TIMEOUT-1 and mem_ready is low (TIMEOUT > 0), that cycle is a forced completion:
    - mem_valid forced to 0.
    - mx_mem_ready = 1 and mx_mem_rdata = ERR_DATA.
    - err_timeout set; next state IDLE.
- mem_ready and timeout in the same cycle: the real completion wins. Slave rdata is returned and err_timeout is not set.
- err_clear and a timeout in the same cycle: set wins.
- mem_ready in IDLE (stray): ignored, and no master sees ready.
- Reset during a GRANT state: transaction abandoned; mem_valid low from the edge that samples reset_n = 0.

Test Plan:
- Write then read on m0 alone: addr 0x80, wdata 42, wstrb 1111; then a read of 0x80 with wstrb 0000 -> m0_mem_rdata = 42. Each transaction shows an IDLE cycle, then grant = 01, then mem_valid.
- Simultaneous requests from cycle 0, RR = 0: m0 reads 0x84, m1 reads 0x88 -> m0 served first, m1 next. m1_mem_ready stays 0 until grant = 10.
- Simultaneous continuous requests, RR = 1, four transactions -> grant sequence 01, 10, 01, 10.
- Slave stubbed with mem_ready tied 0, TIMEOUT = 8 -> forced completion: m1_mem_ready pulses with rdata 0xDEADBEEF, err_timeout = 1. err_clear then gives err_timeout = 0.
- Mid-transaction abort and reset:
  - m1 drops valid while granted -> mem_valid low the same cycle, grant = 00 next cycle, no ready pulse.
  - reset_n pulsed low during GRANT0 -> grant = 00 and mem_valid = 0 after that edge.
- cpu on m1 running addi/add/sw/lw/beq/jal test program loaded through m0 -> mem[0x80] = 30, mem[0x84] = 30, mem[0x88] = 42.
